paddle_ai: RTL and testbench

PADDLE_AI -- requirements
Module: paddle_ai

---
 rtl/pong_pkg.sv | 16 +
 rtl/tick_counter.sv | 23 ++
 rtl/paddle_ai.sv | 75 +++++++
 tb/tb_paddle_ai.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: AI state encoding and default playfield geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOME  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TRACK = 2'd3
  } ai_state_t;

  localparam int PONG_Y_W      = 10;
  localparam int PONG_MIN_Y    = 30;
  localparam int PONG_MAX_Y    = 329;
  localparam int PONG_CENTER_Y = 180;

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter advanced by a tick strobe; flags when it holds 1.
module tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         one
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       count <= '0;
    else if (load)                   count <= load_val;
    else if (tick && count != '0)    count <= count - 1'b1;
  end

  assign one = (count == W'(1));

endmodule

// File: rtl/paddle_ai.sv
// Computer paddle controller: homes to center, waits a reaction delay, then tracks the ball.
module paddle_ai
  import pong_pkg::*;
#(
  parameter int Y_W         = PONG_Y_W,
  parameter int MIN_Y       = PONG_MIN_Y,
  parameter int MAX_Y       = PONG_MAX_Y,
  parameter int CENTER_Y    = PONG_CENTER_Y,
  parameter int DEADBAND    = 4,
  parameter int REACT_TICKS = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           enable,
  input  logic [Y_W-1:0] ball_y,
  input  logic           ball_toward,
  input  logic [Y_W-1:0] paddle_y,
  output logic           up,
  output logic           down,
  output logic [1:0]     state
);

  localparam logic signed [Y_W:0] DB = (Y_W+1)'(DEADBAND);

  ai_state_t             st;
  logic                  cnt_load, cnt_one;
  logic [Y_W-1:0]        target;
  logic signed [Y_W:0]   err;
  logic                  move_ok, want_up, want_dn;

  assign cnt_load = enable && (st == ST_HOME) && ball_toward;

  tick_counter #(.W(8)) u_react (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (8'(REACT_TICKS)),
    .tick     (tick),
    .one      (cnt_one)
  );

  // Moves are judged against the pre-edge state, so a transition never affects its own cycle.
  assign target  = (st == ST_TRACK) ? ball_y : Y_W'(CENTER_Y);
  assign err     = $signed({1'b0, target}) - $signed({1'b0, paddle_y});
  assign move_ok = tick && enable && (st != ST_IDLE);
  assign want_up = move_ok && (err > DB)  && (paddle_y < Y_W'(MAX_Y));
  assign want_dn = move_ok && (err < -DB) && (paddle_y > Y_W'(MIN_Y));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= ST_IDLE;
      up   <= 1'b0;
      down <= 1'b0;
    end else begin
      up   <= want_up;
      down <= want_dn;
      if (!enable) st <= ST_IDLE;
      else begin
        case (st)
          ST_IDLE:  st <= ST_HOME;
          ST_HOME:  if (ball_toward) st <= ST_WAIT;
          // Losing the ball outranks finishing the reaction delay.
          ST_WAIT:  if (!ball_toward)          st <= ST_HOME;
                    else if (tick && cnt_one)  st <= ST_TRACK;
          ST_TRACK: if (!ball_toward) st <= ST_HOME;
          default:  st <= ST_IDLE;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_paddle_ai.sv
// Self-checking bench for paddle_ai: reference model, deadband table, corner sequences, random run.
module tb_paddle_ai;

  logic       clk = 1'b0;
  logic       reset, tick, enable, ball_toward;
  logic [9:0] ball_y, paddle_y;
  logic       up, down;
  logic [1:0] state;

  paddle_ai dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .ball_y(ball_y), .ball_toward(ball_toward), .paddle_y(paddle_y),
    .up(up), .down(down), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: state 0..3 per the rule list, ticks remaining in the reaction delay.
  int m_state = 0, m_rem = 0;
  bit m_up = 0, m_dn = 0;
  bit closed_loop = 0;
  int up_seen = 0, dn_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    int tgt, err, ns;
    if (reset) begin
      m_state = 0; m_rem = 0; m_up = 0; m_dn = 0;
      return;
    end
    tgt  = (m_state == 3) ? int'(ball_y) : 180;
    err  = tgt - int'(paddle_y);
    m_up = tick && enable && m_state != 0 && err > 4  && paddle_y < 329;
    m_dn = tick && enable && m_state != 0 && err < -4 && paddle_y > 30;
    ns = m_state;
    if (!enable) ns = 0;
    else case (m_state)
      0: ns = 1;
      1: if (ball_toward) begin ns = 2; m_rem = 8; end
      2: if (!ball_toward) ns = 1;
         else if (tick) begin
           if (m_rem == 1) ns = 3;
           m_rem--;
         end
      3: if (!ball_toward) ns = 1;
      default: ns = 0;
    endcase
    m_state = ns;
  endfunction

  task automatic step();
    int p;
    @(posedge clk);
    model_edge();
    #1;
    check("state", state, m_state);
    check("up", up, m_up);
    check("down", down, m_dn);
    check("exclusive", up & down, 0);
    if (m_up) up_seen++;
    if (m_dn) dn_seen++;
    if (closed_loop) begin
      p = int'(paddle_y) + (m_up ? 3 : 0) - (m_dn ? 3 : 0);
      if (p > 329) p = 329;
      if (p < 30)  p = 30;
      paddle_y = 10'(p);
    end
  endtask

  task automatic tick_gap(input int gap);
    tick = 1; step();
    tick = 0;
    for (int i = 1; i < gap; i++) step();
  endtask

  task automatic do_reset();
    reset = 1; step(); step();
    check("reset_state", state, 0);
    check("reset_up", up, 0);
    check("reset_down", down, 0);
    reset = 0;
  endtask

  task automatic to_track();
    enable = 1; ball_toward = 0;
    step(); step();
    ball_toward = 1;
    for (int i = 0; i < 40 && m_state != 3; i++) tick_gap(2);
    check("reached_track", state, 3);
  endtask

  typedef struct { int by; int py; bit eu; bit ed; } vec_t;
  vec_t tbl[10];

  initial begin
    int p0;
    tbl[0] = '{200, 196, 0, 0};
    tbl[1] = '{200, 195, 1, 0};
    tbl[2] = '{200, 205, 0, 1};
    tbl[3] = '{200, 204, 0, 0};
    tbl[4] = '{400, 329, 0, 0};
    tbl[5] = '{0,   30,  0, 0};
    tbl[6] = '{400, 328, 1, 0};
    tbl[7] = '{0,   31,  0, 1};
    tbl[8] = '{1023, 0,  1, 0};
    tbl[9] = '{0, 1023,  0, 1};

    reset = 1; tick = 0; enable = 0; ball_toward = 0; ball_y = 0; paddle_y = 180;
    #1;
    check("async_reset_state", state, 0);
    do_reset();

    // Home from top of the field with a delta-3 paddle.
    enable = 1; ball_toward = 0; paddle_y = 300; closed_loop = 1;
    up_seen = 0; dn_seen = 0;
    for (int i = 0; i < 50; i++) tick_gap(10);
    closed_loop = 0;
    check("home_no_up", up_seen, 0);
    check("home_downs", dn_seen, 39);
    check("home_final", int'(paddle_y), 183);

    // Reaction delay from HOME.
    ball_y = 250; paddle_y = 180; ball_toward = 1;
    step();
    check("wait_entry", state, 2);
    up_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      tick = 1; step(); tick = 0;
      check("wait_no_up", up, 0);
      check("wait_state", state, (i < 8) ? 2 : 3);
      step();
    end
    check("delay_up_count", up_seen, 0);
    tick = 1; step(); tick = 0;
    check("ninth_tick_up", up, 1);
    step();

    // Deadband / saturation table in TRACK.
    foreach (tbl[i]) begin
      ball_y = 10'(tbl[i].by); paddle_y = 10'(tbl[i].py);
      tick = 1; step(); tick = 0;
      check($sformatf("tbl%0d_up", i), up, tbl[i].eu);
      check($sformatf("tbl%0d_down", i), down, tbl[i].ed);
      step();
    end

    // Abort during WAIT at count 3.
    ball_toward = 0; step(); step();
    check("back_home", state, 1);
    ball_toward = 1; step();
    for (int i = 0; i < 5; i++) tick_gap(2);
    check("still_wait", state, 2);
    ball_toward = 0; step();
    check("abort_home", state, 1);
    for (int i = 0; i < 4; i++) begin
      tick_gap(2);
      check("no_track_after_abort", state, 1);
    end

    // Tick coincident with enable falling.
    to_track();
    ball_y = 300; paddle_y = 180; enable = 0; tick = 1; step(); tick = 0;
    check("enable_fall_up", up, 0);
    check("enable_fall_state", state, 0);
    step();

    // Async reset mid-TRACK, then reload after reset mid-WAIT.
    to_track();
    ball_y = 300; paddle_y = 180; tick = 1; step(); tick = 0;
    check("pre_reset_up", up, 1);
    #2 reset = 1; #1;
    check("async_rst_state", state, 0);
    check("async_rst_up", up, 0);
    check("async_rst_down", down, 0);
    step(); reset = 0;
    ball_toward = 0; step(); step();
    ball_toward = 1; step();
    for (int i = 0; i < 4; i++) tick_gap(2);
    reset = 1; step(); reset = 0;
    to_track();
    check("reload_ticks", m_state, 3);

    // Closed loop tracking ball at 100.
    ball_y = 100; paddle_y = 180; closed_loop = 1;
    for (int i = 0; i < 40; i++) tick_gap(4);
    p0 = int'(paddle_y);
    check("settle_in_range", (p0 >= 96 && p0 <= 104) ? 1 : 0, 1);
    up_seen = 0; dn_seen = 0;
    for (int i = 0; i < 20; i++) tick_gap(4);
    check("settled_no_moves", up_seen + dn_seen, 0);
    check("settled_hold", int'(paddle_y), p0);
    closed_loop = 0;

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      enable      = ($urandom_range(0, 19) != 0);
      ball_toward = ($urandom_range(0, 9) != 0);
      tick        = ($urandom_range(0, 2) == 0);
      ball_y      = 10'($urandom_range(0, 1023));
      paddle_y    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                : 10'($urandom_range(170, 190));
      step();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
